// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the HI/LO multiply/divide unit.
//   MD_* op encodings as presented on the op port,
//   md_state_e FSM state type, MD_ITER iteration count,
//   small helpers that decode the op field.
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int unsigned MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_SIGN = 2'b10
    } md_state_e;

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle of the multiply/divide unit.
//   master: drives start/op/rs_data/rt_data/mthi/mtlo, observes hi/lo/busy/done/div_zero
//   slave : the unit itself
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_unit_signfix.sv
// muldiv_signfix: combinational sign handling around the unsigned iterator.
//   a_in/b_in, is_signed -> a_abs/b_abs magnitudes and a_neg/b_neg sign flags
//   res_in, is_div, neg_low, neg_high -> res_out
//     multiply: neg_low negates the full 64-bit product
//     divide  : neg_low negates lo (quotient), neg_high negates hi (remainder)
module muldiv_signfix (
    input  logic        is_signed,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] a_abs,
    output logic [31:0] b_abs,
    output logic        a_neg,
    output logic        b_neg,
    input  logic        is_div,
    input  logic        neg_low,
    input  logic        neg_high,
    input  logic [63:0] res_in,
    output logic [63:0] res_out
);

    always_comb begin
        a_neg = is_signed & a_in[31];
        b_neg = is_signed & b_in[31];
        a_abs = a_neg ? (~a_in + 32'd1) : a_in;
        b_abs = b_neg ? (~b_in + 32'd1) : b_in;

        if (!is_div) begin
            res_out = neg_low ? (~res_in + 64'd1) : res_in;
        end else begin
            res_out[63:32] = neg_high ? (~res_in[63:32] + 32'd1) : res_in[63:32];
            res_out[31:0]  = neg_low  ? (~res_in[31:0]  + 32'd1) : res_in[31:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with HI/LO registers.
//   clk, rst (async, active-high)
//   bus.start/op/rs_data/rt_data : operation request, accepted only when idle
//   bus.mthi/mtlo                : move rs_data into hi/lo when idle
//   bus.hi/lo                    : result registers
//   bus.busy                     : operation in progress (IDLE excluded)
//   bus.done                     : one-cycle pulse after hi/lo take a result
//   bus.div_zero                 : sticky divide-by-zero flag, cleared by next start
module muldiv_unit
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    md_state_e   state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    logic [31:0] a_abs, b_abs;
    logic        a_neg, b_neg;
    logic [63:0] fixed;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;

    muldiv_signfix u_signfix (
        .is_signed (md_is_signed(bus.op)),
        .a_in      (bus.rs_data),
        .b_in      (bus.rt_data),
        .a_abs     (a_abs),
        .b_abs     (b_abs),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .is_div    (md_is_div(op_q)),
        .neg_low   (neg_lo_q),
        .neg_high  (neg_hi_q),
        .res_in    (acc_q),
        .res_out   (fixed)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        done_d   = 1'b0;

        // multiply: add multiplicand into the upper half when the multiplier
        // LSB is set, then shift the 65-bit {carry,acc} right by one
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

        // divide: partial remainder shifted left with the next dividend bit;
        // the 33-bit form keeps the bit that would fall off for divisors >= 2^31
        rem_sh  = {acc_q[63:32], acc_q[31]};
        rem_ge  = (rem_sh >= {1'b0, opnd_q});
        rem_sub = rem_sh[31:0] - opnd_q;

        unique case (state_q)
            MD_IDLE: begin
                if (bus.start) begin
                    state_d = MD_CALC;
                    op_d    = bus.op;
                    cnt_d   = '0;
                    if (md_is_div(bus.op)) begin
                        acc_d    = {32'd0, a_abs};
                        opnd_d   = b_abs;
                        dz_d     = (bus.rt_data == '0);
                        // a zero divisor must leave lo all-ones and hi equal to
                        // the raw dividend, so only the remainder sign is restored
                        neg_lo_d = (a_neg ^ b_neg) & (bus.rt_data != '0);
                        neg_hi_d = a_neg;
                    end else begin
                        acc_d    = {32'd0, b_abs};
                        opnd_d   = a_abs;
                        dz_d     = 1'b0;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = 1'b0;
                    end
                end else begin
                    if (bus.mthi) hi_d = bus.rs_data;
                    if (bus.mtlo) lo_d = bus.rs_data;
                end
            end
            MD_CALC: begin
                if (cnt_q == 6'(MD_ITER)) begin
                    state_d = MD_SIGN;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (md_is_div(op_q)) begin
                        acc_d = rem_ge ? {rem_sub, acc_q[30:0], 1'b1}
                                       : {rem_sh[31:0], acc_q[30:0], 1'b0};
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                end
            end
            MD_SIGN: begin
                hi_d    = fixed[63:32];
                lo_d    = fixed[31:0];
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q != MD_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. The driver issues
// directed and random operations and queues the reference result; the
// monitor pops and compares whenever done is seen.
module tb_muldiv_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          passed = 0;
    int          total = 0;

    logic [31:0] mdl_hi, mdl_lo;
    logic        pend;
    logic [31:0] pend_hi, pend_lo;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb_, p;
        logic [63:0] r;
        e.dz  = 1'b0;
        e.cyc = 0;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        if (op == MD_MULT) begin
            p = sa * sb_;
            r = p;
            e.hi = r[63:32];
            e.lo = r[31:0];
        end else if (op == MD_MULTU) begin
            r = {32'd0, a} * {32'd0, b};
            e.hi = r[63:32];
            e.lo = r[31:0];
        end else if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
            e.dz = 1'b1;
        end else if (op == MD_DIV) begin
            p = sa / sb_;
            e.lo = p[31:0];
            p = sa % sb_;
            e.hi = p[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Monitor: compares every done pulse against the oldest queued result.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL spurious_done: got done=1 expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                check("result_hi", bus.hi, mon_e.hi);
                check("result_lo", bus.lo, mon_e.lo);
                check("result_div_zero", bus.div_zero, mon_e.dz);
                check("done_cycle", cyc, mon_e.cyc);
                check("busy_in_done", bus.busy, 1'b0);
            end
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        while (bus.busy && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            total++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles expected busy=0", n);
        end
        if (pend) begin
            mdl_hi = pend_hi;
            mdl_lo = pend_lo;
            pend   = 1'b0;
        end
    endtask

    // Called at a negedge with the unit idle; returns one cycle after E0.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(op, a, b);
        e.cyc = cyc + 35;
        sb.push_back(e);
        pend = 1'b1;
        pend_hi = e.hi;
        pend_lo = e.lo;
        bus.start = 1'b1;
        bus.op = op;
        bus.rs_data = a;
        bus.rt_data = b;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1'b1);
        check("div_zero_at_start", bus.div_zero, e.dz);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        issue(op, a, b);
        repeat (9) @(negedge clk);
        check("hold_hi", bus.hi, mdl_hi);
        check("hold_lo", bus.lo, mdl_lo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        pend = 1'b0;
        pend_hi = '0;
        pend_lo = '0;
        repeat (3) @(negedge clk);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_div_zero", bus.div_zero, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // directed scenarios; each start lands in the previous done cycle
        run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(MD_DIVU,  32'h0000_1234, 32'd0);
        run_op(MD_DIV,   32'h8000_0005, 32'd0);
        run_op(MD_MULT,  32'd7, 32'd9);

        // start and mthi while busy are ignored
        wait_idle();
        issue(MD_MULTU, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op = MD_DIV;
        bus.rs_data = 32'd123;
        bus.rt_data = 32'd0;
        bus.mthi = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi = 1'b0;
        check("busy_start_div_zero", bus.div_zero, 1'b0);
        check("busy_mthi_hi", bus.hi, mdl_hi);

        // moves while idle land at the next edge
        wait_idle();
        bus.mthi = 1'b1;
        bus.rs_data = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi_idle", bus.hi, 32'hA5A5_A5A5);
        mdl_hi = 32'hA5A5_A5A5;
        bus.mtlo = 1'b1;
        bus.rs_data = 32'h5A5A_0F0F;
        @(negedge clk);
        bus.mtlo = 1'b0;
        check("mtlo_idle", bus.lo, 32'h5A5A_0F0F);
        mdl_lo = 32'h5A5A_0F0F;

        // start beats a simultaneous mthi
        bus.mthi = 1'b1;
        issue(MD_MULTU, 32'd2, 32'd3);
        bus.mthi = 1'b0;
        check("start_priority_hi", bus.hi, mdl_hi);

        // reset in the middle of CALC aborts with nothing written
        wait_idle();
        issue(MD_MULT, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        sb.delete();
        pend = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op(MD_MULT, 32'd5, 32'd6);

        // randomized operations with biased edge operands
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
